mult_div_unit: RTL

//  Multiply/divide unit downstream of the register file. Consumes the two GPR

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//
// Multiply/divide unit that sits behind the register file read ports. It runs
// MULT/MULTU/DIV/DIVU (and optionally MADD/MADDU) as a fixed-latency
// operation into private HI/LO registers. Busy is exported to the hazard unit.
//
// Ports
//   Clk    in   1   clock, rising edge
//   Reset  in   1   asynchronous, active-high; clears all state
//   Start  in   1   launch the op selected by Op with operands A/B
//   Op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6-7 reserved
//   A      in   32  operand rs; also write data for MTHI/MTLO
//   B      in   32  operand rt
//   MTHI   in   1   write A into HI (idle only)
//   MTLO   in   1   write A into LO (idle only)
//   Busy   out  1   operation in flight
//   HI     out  32  HI register (registered, no bypass)
//   LO     out  32  LO register (registered, no bypass)
//
// Configuration
//   MDU_MADD_EN  when defined, Op 4/5 accumulate the product into {HI,LO};
//                when undefined, Op 4/5 are reserved and no accumulator
//                adder is built.

module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MTHI,
    input  logic        MTLO,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } stateT;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    stateT       state;
    stateT       stateNext;
    logic [3:0]  count;
    logic [3:0]  countNext;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        loadPend;
    logic        commit;
    logic        hiWe;
    logic        loWe;
    logic        validOp;
    logic        isDiv;
    logic [63:0] result;

    logic [63:0] signedProd;
    logic [63:0] unsignedProd;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] signedDivisor;
    logic [31:0] unsignedDivisor;
    logic [31:0] magQuot;
    logic [31:0] magRem;
    logic [31:0] signedQuot;
    logic [31:0] signedRem;
    logic [31:0] unsignedQuot;
    logic [31:0] unsignedRem;

    // Both products are built at full 64-bit width so HI gets the real upper half.
    assign signedProd   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign unsignedProd = {32'd0, A} * {32'd0, B};

    // Signed division works on magnitudes and fixes up signs afterwards. This
    // makes 0x80000000 / -1 wrap to 0x80000000 naturally instead of relying on
    // a signed divider's overflow behaviour. The divisor is forced to 1 when
    // B is zero so the divider never sees zero; that case is muxed out below.
    assign absA            = A[31] ? (~A + 32'd1) : A;
    assign absB            = B[31] ? (~B + 32'd1) : B;
    assign signedDivisor   = (B == 32'd0) ? 32'd1 : absB;
    assign unsignedDivisor = (B == 32'd0) ? 32'd1 : B;
    assign magQuot         = absA / signedDivisor;
    assign magRem          = absA % signedDivisor;
    assign signedQuot      = (A[31] ^ B[31]) ? (~magQuot + 32'd1) : magQuot;
    assign signedRem       = A[31] ? (~magRem + 32'd1) : magRem;
    assign unsignedQuot    = A / unsignedDivisor;
    assign unsignedRem     = A % unsignedDivisor;

    // Decode which ops are legal in this build and which use the divide latency.
    always_comb begin
        validOp = 1'b0;
        isDiv   = 1'b0;
        case (Op)
            3'd0, 3'd1: validOp = 1'b1;
            3'd2, 3'd3: begin
                validOp = 1'b1;
                isDiv   = 1'b1;
            end
`ifdef MDU_MADD_EN
            3'd4, 3'd5: validOp = 1'b1;
`endif
            default: validOp = 1'b0;
        endcase
    end

    // The whole result is computed at the Start edge and parked in pending
    // registers; the busy countdown only models latency. The accumulate base
    // for MADD/MADDU is therefore {HI,LO} as seen at the Start edge.
    always_comb begin
        result = {HI, LO};
        case (Op)
            3'd0: result = signedProd;
            3'd1: result = unsignedProd;
            3'd2: result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {signedRem, signedQuot};
            3'd3: result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {unsignedRem, unsignedQuot};
`ifdef MDU_MADD_EN
            3'd4: result = {HI, LO} + signedProd;
            3'd5: result = {HI, LO} + unsignedProd;
`endif
            default: result = {HI, LO};
        endcase
    end

    // Next-state logic. In idle a valid Start takes priority over MTHI/MTLO;
    // in busy everything on the inputs is ignored and the counter runs down,
    // committing the pending result on the edge where it reads 1.
    always_comb begin
        stateNext = state;
        countNext = count;
        loadPend  = 1'b0;
        commit    = 1'b0;
        hiWe      = 1'b0;
        loWe      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && validOp) begin
                    stateNext = ST_BUSY;
                    countNext = isDiv ? DIV_LOAD : MULT_LOAD;
                    loadPend  = 1'b1;
                end else begin
                    hiWe = MTHI;
                    loWe = MTLO;
                end
            end
            ST_BUSY: begin
                countNext = count - 4'd1;
                if (count <= 4'd1) begin
                    countNext = 4'd0;
                    commit    = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, counter, pending result and the architectural HI/LO registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            count  <= 4'd0;
            pendHi <= 32'd0;
            pendLo <= 32'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (loadPend) begin
                pendHi <= result[63:32];
                pendLo <= result[31:0];
            end
            if (commit) begin
                HI <= pendHi;
                LO <= pendLo;
            end else begin
                if (hiWe) begin
                    HI <= A;
                end
                if (loWe) begin
                    LO <= A;
                end
            end
        end
    end

    assign Busy = (state == ST_BUSY);

endmodule
